// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// operation codes and FSM state encodings.
package muldiv_ctrl_pkg;

  typedef logic [1:0] md_op_t;

  localparam md_op_t MD_MULT  = 2'b00;
  localparam md_op_t MD_MULTU = 2'b01;
  localparam md_op_t MD_DIV   = 2'b10;
  localparam md_op_t MD_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_ZERO = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  // Bit 1 of the op code selects divide over multiply.
  function automatic logic md_is_div(input md_op_t op);
    return op[1];
  endfunction

  // MULT and DIV treat their operands as two's complement.
  function automatic logic md_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage <-> multiply/divide sequencer handshake bundle.
interface muldiv_ctrl_if
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);

  logic               start_i;
  md_op_t             op_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stallreq_o;

  // EX stage side
  modport master (
    output start_i, op_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  // Sequencer side
  modport slave (
    input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stallreq_o
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath.
// Divide: restoring trial-subtract on acc = {remainder, dividend/quotient}.
// Multiply: conditional add of the multiplicand into acc[hi], then shift right,
// with the multiplier consumed from acc[lo].
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               i_is_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0] w_partial;
  logic [WIDTH:0] w_diff;
  logic           w_ge;
  logic [WIDTH:0] w_sum;

  // Compute both step flavours and select by op class.
  always_comb begin
    // Divide: shifted remainder with the next dividend bit brought in.
    w_partial = i_acc[2*WIDTH-1:WIDTH-1];
    w_ge      = w_partial >= {1'b0, i_opnd};
    w_diff    = w_partial - {1'b0, i_opnd};
    // Multiply: add multiplicand when the current multiplier bit is set.
    w_sum     = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);

    if (i_is_div) begin
      // Remainder stays below the divisor, so the difference fits in WIDTH bits.
      o_acc = w_ge ? {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1}
                   : {i_acc[2*WIDTH-2:0], 1'b0};
    end else begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer for the EX stage. Works on operand
// magnitudes one bit per cycle, applies sign correction when the last step
// completes, and holds the pipeline via stallreq_o while busy.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic           clk,
  input logic           rst,
  muldiv_ctrl_if.slave  bus
);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  md_op_t             r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_res_neg;
  logic               r_dvd_neg;
  logic [2*WIDTH-1:0] r_result;

  logic               w_signed_in;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic               w_accept;
  logic               w_div_zero;
  logic               w_last;
  logic [2*WIDTH-1:0] w_acc_step;
  logic [2*WIDTH-1:0] w_final;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_is_div (md_is_div(r_op)),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_acc_step)
  );

  // Operand magnitudes and acceptance decode for the IDLE cycle.
  always_comb begin
    w_signed_in = md_is_signed(bus.op_i);
    // Most-negative value maps onto itself, which is its correct unsigned magnitude.
    w_abs1      = (w_signed_in && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
    w_abs2      = (w_signed_in && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;
    w_accept    = (r_state == S_IDLE) && bus.start_i && !bus.annul_i;
    w_div_zero  = md_is_div(bus.op_i) && (bus.opdata2_i == '0);
    w_last      = r_cnt == CNT_W'(WIDTH - 1);
  end

  // Sign-corrected result from the final step, captured on RUN->DONE.
  always_comb begin
    w_quo = w_acc_step[WIDTH-1:0];
    w_rem = w_acc_step[2*WIDTH-1:WIDTH];
    if (md_is_div(r_op)) begin
      w_final = {(r_dvd_neg ? -w_rem : w_rem), (r_res_neg ? -w_quo : w_quo)};
    end else begin
      w_final = r_res_neg ? -w_acc_step : w_acc_step;
    end
  end

  // Next-state decode; annul abandons RUN/ZERO but never DONE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_div_zero ? S_ZERO : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.annul_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_ZERO:  w_state_nxt = bus.annul_i ? S_IDLE : S_DONE;
      S_DONE:  w_state_nxt = bus.start_i ? S_DONE : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, iteration counter, sign bookkeeping and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= MD_MULT;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_res_neg <= 1'b0;
      r_dvd_neg <= 1'b0;
      r_result  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op      <= bus.op_i;
        r_cnt     <= '0;
        r_res_neg <= w_signed_in && (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
        r_dvd_neg <= w_signed_in && md_is_div(bus.op_i) && bus.opdata1_i[WIDTH-1];
        if (md_is_div(bus.op_i)) begin
          r_acc  <= {{WIDTH{1'b0}}, w_abs1};
          r_opnd <= w_abs2;
        end else begin
          r_acc  <= {{WIDTH{1'b0}}, w_abs2};
          r_opnd <= w_abs1;
        end
      end else if ((r_state == S_RUN) && !bus.annul_i) begin
        r_acc <= w_acc_step;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_result <= w_final;
        end
      end else if (r_state == S_ZERO) begin
        r_result <= '0;
      end
    end
  end

  // Outputs: result only visible while DONE; stall while accepting or busy.
  always_comb begin
    bus.ready_o    = r_state == S_DONE;
    bus.result_o   = (r_state == S_DONE) ? r_result : '0;
    bus.stallreq_o = w_accept ||
                     (((r_state == S_RUN) || (r_state == S_ZERO)) && !bus.annul_i);
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomised and directed bench for muldiv_ctrl against an arithmetic model.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_ctrl_if #(.WIDTH(W)) bus ();

  muldiv_ctrl #(
    .WIDTH (W),
    .CNT_W (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // {HI,LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      MD_MULT: begin
        p = 64'(sa * sb);
        return p;
      end
      MD_MULTU: return ua * ub;
      MD_DIVU: begin
        if (b == 0) return 64'b0;
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: begin
        if (b == 0) return 64'b0;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Called just after a negedge with the block idle; returns just after a
  // negedge with the block back in IDLE.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [63:0] exp_res;
    logic [63:0] res;
    int exp_lat, cyc, stall_bad;
    exp_res = ref_model(op, a, b);
    exp_lat = (op[1] && b == 0) ? 2 : W + 1;
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    #1;
    check("stall_accept", 64'(bus.stallreq_o), 64'd1);
    cyc = 0;
    stall_bad = 0;
    while (!bus.ready_o && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
      if (!bus.ready_o && !bus.stallreq_o) stall_bad++;
    end
    check("latency", 64'(cyc), 64'(exp_lat));
    check("stall_busy", 64'(stall_bad), 64'd0);
    check("result", bus.result_o, exp_res);
    check("stall_done", 64'(bus.stallreq_o), 64'd0);
    res = bus.result_o;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      check("hold_ready", 64'(bus.ready_o), 64'd1);
      check("hold_result", bus.result_o, res);
    end
    bus.start_i   = 1'b0;
    bus.op_i      = 2'($urandom_range(0, 3));
    bus.opdata1_i = $urandom;
    bus.opdata2_i = $urandom;
    @(negedge clk);
    #1;
    check("release_ready", 64'(bus.ready_o), 64'd0);
    check("release_result", bus.result_o, 64'd0);
    check("release_stall", 64'(bus.stallreq_o), 64'd0);
  endtask

  task automatic watch_no_ready(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      if (bus.ready_o || bus.stallreq_o) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          stall_bad;

    rst           = 1'b1;
    bus.start_i   = 1'b0;
    bus.op_i      = MD_MULT;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.annul_i   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 64'(bus.ready_o), 64'd0);
    check("rst_stall", 64'(bus.stallreq_o), 64'd0);
    check("rst_result", bus.result_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;

    // Directed cases; back-to-back starts follow each release.
    run_op(MD_DIVU, 32'd100, 32'd7, 3);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1);
    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, 0);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 2);
    run_op(MD_DIVU, 32'd5, 32'd0, 3);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd0, 1);
    run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, 0);

    // Annul in RUN at cycle 10: back to IDLE, no ready.
    bus.start_i   = 1'b1;
    bus.op_i      = MD_DIV;
    bus.opdata1_i = $urandom;
    bus.opdata2_i = $urandom | 32'd1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
    end
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    #1;
    check("annul_stall_now", 64'(bus.stallreq_o), 64'd0);
    @(negedge clk);
    #1;
    bus.annul_i = 1'b0;
    check("annul_ready", 64'(bus.ready_o), 64'd0);
    check("annul_stall", 64'(bus.stallreq_o), 64'd0);
    watch_no_ready("annul_quiet", 40);

    // Annul in IDLE suppresses acceptance.
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    bus.op_i    = MD_MULTU;
    stall_bad = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus.stallreq_o || bus.ready_o) stall_bad++;
      @(negedge clk);
    end
    #1;
    check("annul_idle", 64'(stall_bad), 64'd0);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    watch_no_ready("annul_idle_quiet", 40);

    // Synchronous reset at cycle 10 of a multiply.
    bus.start_i   = 1'b1;
    bus.op_i      = MD_MULT;
    bus.opdata1_i = $urandom;
    bus.opdata2_i = $urandom;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
    end
    rst         = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_ready", 64'(bus.ready_o), 64'd0);
    check("midrst_stall", 64'(bus.stallreq_o), 64'd0);
    check("midrst_result", bus.result_o, 64'd0);
    rst = 1'b0;
    watch_no_ready("midrst_quiet", 40);

    // Randomised operations.
    for (int i = 0; i < 16; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_op(op, a, b, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer serving the EX stage for MULT, MULTU, DIV and DIVU.
- Accepts operands from EX and holds the pipeline via stallreq_o while it iterates one bit per cycle.
- Returns the 64-bit {HI,LO} result for the HI/LO write path; later MFHI/MFLO instructions read it through the normal move path.
- Supports annulment when the issuing instruction is flushed.

Parameters:
- WIDTH, 32, operand width; result width is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset
- start_i  in  1  EX requests an operation; held high until ready_o has been seen
- op_i  in  2  operation select: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU
- opdata1_i  in  WIDTH  rs value: multiplicand or dividend
- opdata2_i  in  WIDTH  rt value: multiplier or divisor
- annul_i  in  1  cancel the current operation (flush or exception)
- result_o  out  2*WIDTH  {HI,LO}; multiply gives the product, divide gives {remainder, quotient}
- ready_o  out  1  result_o valid
- stallreq_o  out  1  stall request to the pipeline controller

Behaviour:
- Reset: rst is synchronous, active-high. It forces state IDLE, counter 0, result_o 0, ready_o 0, stallreq_o 0. Reset mid-operation abandons the operation with no partial result visible.
- States: IDLE, ZERO, RUN, DONE.
- IDLE:
  - On start_i=1 and annul_i=0: latch op_i and operands. For signed ops, latch the absolute values and record the result sign and dividend sign.
  - If op is DIV/DIVU and opdata2_i==0, go to ZERO; otherwise go to RUN with counter=0.
  - stallreq_o=1 combinationally in the accept cycle.
- RUN:
  - One shift-subtract (divide) or shift-add (multiply) step per cycle; counter increments.
  - After the step with counter==WIDTH-1, go to DONE.
  - stallreq_o=1 throughout.
- ZERO: result register := 0; go to DONE next cycle; stallreq_o=1.
- DONE:
  - ready_o=1, stallreq_o=0, result_o stable.
  - Stay in DONE while start_i=1; return to IDLE when start_i=0.
  - ready_o and result_o then return to 0 in IDLE.
- Latency, with the start-accept cycle as cycle 0:
  - Multiply and non-zero divide: ready_o first high in cycle WIDTH+1 (cycle 33).
  - Divide-by-zero: ready_o first high in cycle 2.
- annul_i:
  - In IDLE, suppresses acceptance.
  - In RUN or ZERO, the next state is IDLE, stallreq_o drops that cycle, and no ready_o is produced.
  - In DONE, it is ignored.
- Divide: restoring algorithm, unsigned internally.
  - Signed correction: quotient negated iff the operand signs differ; remainder takes the dividend's sign.
  - Most-negative dividend is handled through its WIDTH-bit unsigned magnitude; results wrap mod 2^WIDTH.
- Multiply: unsigned shift-add on magnitudes into a 2*WIDTH accumulator. For MULT, the product is two's-complement negated if the signs differ.
- Sign correction happens on the RUN->DONE transition; ready_o never shows an uncorrected value.
- A new start_i is ignored unless the block is in IDLE.

Decomposition:
- Shared defines file: MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11; state encodings.
- Sub-module muldiv_step: combinational single-iteration step.
  - Inputs: op class, accumulator, operand. Outputs: next accumulator.
  - Covers both the divide trial-subtract and the multiply conditional-add.
- Controller keeps the FSM, counter, sign bookkeeping and the result register.

Test Plan:
- DIVU 100/7 -> stallreq_o high cycles 0-32; ready_o at cycle 33; result_o = {32'd2, 32'd14}.
- DIV -7/2 -> result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}.
- MULT -3*5 -> result_o = 64'hFFFFFFFF_FFFFFFF1. MULTU 32'hFFFFFFFF*2 -> 64'h00000001_FFFFFFFE.
- DIVU 5/0 -> ready_o at cycle 2, result_o = 0, stallreq_o low from cycle 2.
- Annul and reset during an operation:
  - annul_i pulse at cycle 10 of DIV -> IDLE next cycle, stallreq_o low, ready_o never asserted.
  - rst at cycle 10 -> all outputs 0 next cycle.
- Hold and release: start_i held 3 cycles into DONE -> ready_o and result_o stable all 3 cycles. start_i low -> IDLE, ready_o 0. A new start is accepted the next cycle.
